// File: rtl/regheap_pkg.sv
// Shared definitions for the 64x16b self-adding regheap, its upstream feeder
// and the drain controller: heap geometry, the controller phase type and a
// per-lane ReLU helper.
package regheap_pkg;

  localparam int LANE_W = 16;
  localparam int NLANES = 64;
  localparam int HEAP_W = LANE_W * NLANES;

  typedef enum logic [1:0] {
    PH_ACC  = 2'd0,
    PH_WAIT = 2'd1,
    PH_SNAP = 2'd2
  } phase_e;

  // Signed 16b lane clamped at zero: negative lanes become 0, others pass.
  function automatic logic [LANE_W-1:0] relu_lane(input logic [LANE_W-1:0] v);
    if (v[LANE_W-1]) begin
      return {LANE_W{1'b0}};
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/regheap_beat_ser.sv
// Snapshot serializer for the regheap drain: holds the captured 1024b heap
// image and emits it low lanes first as BEAT_W-bit beats on valid/ready.
// Optional feature macro: REGHEAP_DRAIN_RELU_EN (negative lanes output as 0;
// the stored snapshot itself is never modified).
module regheap_beat_ser
  import regheap_pkg::*;
#(
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [HEAP_W-1:0] i_data,
  input  logic              i_out_rdy,
  output logic [BEAT_W-1:0] o_out_data,
  output logic              o_out_v,
  output logic              o_out_last,
  output logic              o_idle,
  output logic              o_last_done
);

  localparam int NBEATS = HEAP_W / BEAT_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBEATS - 1);

  logic [HEAP_W-1:0] r_snap;
  logic [IDX_W-1:0]  r_idx;
  logic              r_active;
  logic              w_hs;
  logic              w_at_last;
  logic [BEAT_W-1:0] w_beats [NBEATS];
  logic [BEAT_W-1:0] w_beat;
  logic [BEAT_W-1:0] w_beat_q;

  // Beat k of the snapshot as a constant slice, so the mux index stays narrow.
  for (genvar k = 0; k < NBEATS; k++) begin : g_beat
    assign w_beats[k] = r_snap[k*BEAT_W +: BEAT_W];
  end

  assign w_hs      = r_active & i_out_rdy;
  assign w_at_last = (r_idx == IDX_LAST);
  assign w_beat    = w_beats[r_idx];

  // Capture a new snapshot on load; otherwise advance one beat per handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap   <= {HEAP_W{1'b0}};
      r_idx    <= {IDX_W{1'b0}};
      r_active <= 1'b0;
    end else if (i_load) begin
      r_snap   <= i_data;
      r_idx    <= {IDX_W{1'b0}};
      r_active <= 1'b1;
    end else if (w_hs) begin
      if (w_at_last) begin
        r_active <= 1'b0;
        r_idx    <= {IDX_W{1'b0}};
      end else begin
        r_idx    <= r_idx + IDX_W'(1);
      end
    end
  end

  // Post-mux lane treatment: pass-through, or ReLU when the feature is built in.
  always_comb begin
    w_beat_q = w_beat;
`ifdef REGHEAP_DRAIN_RELU_EN
    for (int l = 0; l < BEAT_W / LANE_W; l++) begin
      w_beat_q[l*LANE_W +: LANE_W] = relu_lane(w_beat[l*LANE_W +: LANE_W]);
    end
`endif
  end

  // Data is forced to zero whenever no beat is being offered.
  assign o_out_data  = r_active ? w_beat_q : {BEAT_W{1'b0}};
  assign o_out_v     = r_active;
  assign o_out_last  = r_active & w_at_last;
  assign o_idle      = ~r_active;
  assign o_last_done = w_hs & w_at_last;

endmodule

// File: rtl/regheap_drain_ctrl.sv
// Loop controller and drain stage behind the 64x16b self-adding regheap.
// Counts ACC_LEN accepted beats, waits HEAP_LAT cycles for the heap to
// settle, snapshots it while pulsing usr_rst, and hands the snapshot to the
// beat serializer so the next accumulation overlaps the drain.
// Optional feature macro: REGHEAP_DRAIN_RELU_EN (handled in regheap_beat_ser).
module regheap_drain_ctrl
  import regheap_pkg::*;
#(
  parameter int ACC_LEN  = 16,
  parameter int HEAP_LAT = 2,
  parameter int BEAT_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_v,
  output logic              acc_rdy,
  input  logic [HEAP_W-1:0] heap_data,
  output logic              usr_rst,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_v,
  input  logic              out_rdy,
  output logic              out_last,
  output logic              busy
);

  localparam int ACC_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(ACC_LEN - 1);
  localparam logic [2:0]       WAIT_INIT = 3'(HEAP_LAT);

  phase_e           r_phase;
  phase_e           w_phase_nxt;
  logic [ACC_W-1:0] r_acc_cnt;
  logic [ACC_W-1:0] w_acc_cnt_nxt;
  logic [2:0]       r_wait_cnt;
  logic [2:0]       w_wait_cnt_nxt;
  logic             r_acc_rdy;
  logic             r_usr_rst;
  logic             w_accept;
  logic             w_drain_free;
  logic             w_load;
  logic             w_idle;
  logic             w_last_done;

  assign w_accept     = acc_v & r_acc_rdy;
  // The drain may be reloaded if idle or if its final handshake happens now.
  assign w_drain_free = w_idle | w_last_done;
  assign w_load       = (r_phase == PH_SNAP);

  // Phase sequencing. The wait counter holds the number of WAIT cycles still
  // to spend, so SNAP lands HEAP_LAT+1 cycles after the last accepted beat
  // and HEAP_LAT=0 goes straight to SNAP when the drain is free.
  always_comb begin
    w_phase_nxt    = r_phase;
    w_acc_cnt_nxt  = r_acc_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_phase)
      PH_ACC: begin
        if (w_accept) begin
          if (r_acc_cnt == ACC_LAST) begin
            w_wait_cnt_nxt = WAIT_INIT;
            if ((WAIT_INIT == 3'd0) && w_drain_free) begin
              w_phase_nxt = PH_SNAP;
            end else begin
              w_phase_nxt = PH_WAIT;
            end
          end else begin
            w_acc_cnt_nxt = r_acc_cnt + ACC_W'(1);
          end
        end else begin
          w_phase_nxt = PH_ACC;
        end
      end
      PH_WAIT: begin
        if ((r_wait_cnt <= 3'd1) && w_drain_free) begin
          w_phase_nxt = PH_SNAP;
        end else begin
          w_phase_nxt = PH_WAIT;
        end
        if (r_wait_cnt != 3'd0) begin
          w_wait_cnt_nxt = r_wait_cnt - 3'd1;
        end else begin
          w_wait_cnt_nxt = 3'd0;
        end
      end
      PH_SNAP: begin
        w_phase_nxt    = PH_ACC;
        w_acc_cnt_nxt  = {ACC_W{1'b0}};
        w_wait_cnt_nxt = 3'd0;
      end
      default: begin
        w_phase_nxt    = PH_ACC;
        w_acc_cnt_nxt  = {ACC_W{1'b0}};
        w_wait_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Phase/counter state plus acc_rdy and usr_rst registered from the next phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase    <= PH_ACC;
      r_acc_cnt  <= {ACC_W{1'b0}};
      r_wait_cnt <= 3'd0;
      r_acc_rdy  <= 1'b1;
      r_usr_rst  <= 1'b0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_acc_cnt  <= w_acc_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_acc_rdy  <= (w_phase_nxt == PH_ACC);
      r_usr_rst  <= (w_phase_nxt == PH_SNAP);
    end
  end

  regheap_beat_ser #(
    .BEAT_W (BEAT_W)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_data      (heap_data),
    .i_out_rdy   (out_rdy),
    .o_out_data  (out_data),
    .o_out_v     (out_v),
    .o_out_last  (out_last),
    .o_idle      (w_idle),
    .o_last_done (w_last_done)
  );

  assign acc_rdy = r_acc_rdy;
  assign usr_rst = r_usr_rst;
  assign busy    = (r_phase != PH_ACC) | ~w_idle;

endmodule

// File: tb/tb_regheap_drain_ctrl.sv
// Self-checking bench for regheap_drain_ctrl (ACC_LEN=16, HEAP_LAT=2, BEAT_W=64).
// A behavioural regheap adds accepted lane vectors into the heap and makes
// them visible a few cycles later; a scoreboard pushes the expected beats of
// each frame when its final beat is accepted and pops them on every output
// handshake. Expected values follow REGHEAP_DRAIN_RELU_EN when defined.
module tb_regheap_drain_ctrl;
  import regheap_pkg::*;

  localparam int ACC_LEN  = 16;
  localparam int HEAP_LAT = 2;
  localparam int BEAT_W   = 64;
  localparam int NB       = HEAP_W / BEAT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              acc_v = 1'b0;
  logic              out_rdy = 1'b0;
  logic              acc_rdy, usr_rst, out_v, out_last, busy;
  logic [HEAP_W-1:0] heap_data = '0;
  logic [BEAT_W-1:0] out_data;

  always #5 clk = ~clk;

  regheap_drain_ctrl #(.ACC_LEN(ACC_LEN), .HEAP_LAT(HEAP_LAT), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst), .acc_v(acc_v), .acc_rdy(acc_rdy), .heap_data(heap_data),
    .usr_rst(usr_rst), .out_data(out_data), .out_v(out_v), .out_rdy(out_rdy),
    .out_last(out_last), .busy(busy)
  );

  int n_pass = 0, n_total = 0, cyc = 0;
  int exp_cnt = 0, usr_rst_cnt = 0, usr_rst_cyc = 0, last_acc_cyc = 0, hs_cnt = 0;
  logic [HEAP_W-1:0] add_vec = '0, exp_acc = '0, m_vec = '0, d1_vec = '0, d2_vec = '0;
  logic m_fire = 1'b0, m_usr_rst = 1'b0, d1_v = 1'b0, d2_v = 1'b0, stalled = 1'b0;
  logic [BEAT_W-1:0] held = '0;
  logic [BEAT_W-1:0] q_data[$];
  logic              q_last[$];

  function automatic logic [HEAP_W-1:0] vadd(input logic [HEAP_W-1:0] a, input logic [HEAP_W-1:0] b);
    logic [HEAP_W-1:0] r;
    for (int i = 0; i < NLANES; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
    return r;
  endfunction

  function automatic logic [BEAT_W-1:0] exp_beat(input logic [HEAP_W-1:0] img, input int k);
    logic [BEAT_W-1:0] b;
    b = img[k*BEAT_W +: BEAT_W];
`ifdef REGHEAP_DRAIN_RELU_EN
    for (int j = 0; j < BEAT_W / 16; j++) if (b[j*16+15]) b[j*16 +: 16] = 16'h0000;
`endif
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural regheap: an accepted vector becomes visible three edges later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      heap_data <= '0; d1_v <= 1'b0; d2_v <= 1'b0; d1_vec <= '0; d2_vec <= '0;
    end else begin
      if (m_usr_rst) heap_data <= '0;
      else if (d2_v) heap_data <= vadd(heap_data, d2_vec);
      d2_v <= d1_v; d2_vec <= d1_vec; d1_v <= m_fire; d1_vec <= m_vec;
    end
  end

  // Mid-cycle monitor: accept tracking, scoreboard push/pop, stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      q_data.delete(); q_last.delete();
      exp_acc = '0; exp_cnt = 0; stalled = 1'b0; m_fire = 1'b0; m_usr_rst = 1'b0;
    end else begin
      m_fire = acc_v & acc_rdy; m_vec = add_vec; m_usr_rst = usr_rst;
      if (usr_rst) begin usr_rst_cnt++; usr_rst_cyc = cyc; end
      if (m_fire) begin
        exp_acc = vadd(exp_acc, add_vec); exp_cnt++;
        if (exp_cnt == ACC_LEN) begin
          last_acc_cyc = cyc;
          for (int k = 0; k < NB; k++) begin q_data.push_back(exp_beat(exp_acc, k)); q_last.push_back(k == NB - 1); end
          exp_acc = '0; exp_cnt = 0;
        end
      end
      if (stalled) begin
        n_total++;
        if (out_v !== 1'b1 || out_data !== held) $display("FAIL stall_hold: out_v=%b data=%h required 1/%h", out_v, out_data, held);
        else n_pass++;
      end
      if (out_v && out_rdy) begin
        logic [BEAT_W-1:0] ed; logic el;
        hs_cnt++; n_total++;
        if (q_data.size() == 0) $display("FAIL beat_unexpected: data=%h with empty scoreboard", out_data);
        else begin
          ed = q_data.pop_front(); el = q_last.pop_front();
          if (out_data !== ed || out_last !== el) $display("FAIL beat_data: got %h last=%b required %h last=%b", out_data, out_last, ed, el);
          else n_pass++;
        end
      end
      stalled = out_v & ~out_rdy; held = out_data;
    end
  end

  task automatic feed(input int nbeats, input int mode);
    int got = 0, g = 0;
    while (got < nbeats && g < 2000) begin
      acc_v = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      add_vec = '0;
      case (mode)
        0: for (int i = 0; i < NLANES; i++) add_vec[i*16 +: 16] = 16'h0001;
        3: if (got == 0) begin add_vec[15:0] = 16'hFFFE; add_vec[31:16] = 16'h7FFF; end
        default: for (int i = 0; i < HEAP_W / 32; i++) add_vec[i*32 +: 32] = $urandom();
      endcase
      @(negedge clk); if (acc_v && acc_rdy) got++;
      @(posedge clk); #1; g++;
    end
    acc_v = 1'b0; add_vec = '0;
    n_total++;
    if (got !== nbeats) $display("FAIL feed_budget: accepted %0d required %0d", got, nbeats); else n_pass++;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while ((q_data.size() != 0 || out_v || busy) && g < 600) begin @(negedge clk); g++; end
    n_total++;
    if (q_data.size() != 0 || out_v || busy) $display("FAIL %s_idle: pending=%0d out_v=%b busy=%b required 0/0/0", tag, q_data.size(), out_v, busy);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total += 6;
    if (acc_rdy !== 1'b1) $display("FAIL rst_acc_rdy: got %b required 1", acc_rdy); else n_pass++;
    if (usr_rst !== 1'b0) $display("FAIL rst_usr_rst: got %b required 0", usr_rst); else n_pass++;
    if (out_v !== 1'b0) $display("FAIL rst_out_v: got %b required 0", out_v); else n_pass++;
    if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b required 0", out_last); else n_pass++;
    if (out_data !== 64'h0) $display("FAIL rst_out_data: got %h required 0", out_data); else n_pass++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int u0 = usr_rst_cnt, h0 = hs_cnt, g = 0;
    logic [63:0] first_exp = {4{16'h0010}};
    out_rdy = 1'b1;
    feed(ACC_LEN, 0);
    while (!out_v && g < 20) begin @(negedge clk); g++; end
    n_total += 2;
    if (out_data !== first_exp || out_last !== 1'b0) $display("FAIL basic_first_beat: got %h last=%b required %h last=0", out_data, out_last, first_exp); else n_pass++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", busy); else n_pass++;
    wait_idle("basic");
    n_total += 3;
    if (usr_rst_cnt - u0 !== 1) $display("FAIL basic_usr_rst_count: got %0d required 1", usr_rst_cnt - u0); else n_pass++;
    if (usr_rst_cyc - last_acc_cyc !== HEAP_LAT + 1) $display("FAIL basic_snap_latency: got %0d required %0d", usr_rst_cyc - last_acc_cyc, HEAP_LAT + 1); else n_pass++;
    if (hs_cnt - h0 !== NB) $display("FAIL basic_beats: got %0d required %0d", hs_cnt - h0, NB); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int got = 0, low = 0, g = 0, u0 = usr_rst_cnt;
    out_rdy = 1'b1;
    while (got < 3 * ACC_LEN && g < 400) begin
      acc_v = 1'b1;
      for (int i = 0; i < HEAP_W / 32; i++) add_vec[i*32 +: 32] = $urandom();
      @(negedge clk); if (!acc_rdy) low++; else got++;
      @(posedge clk); #1; g++;
    end
    acc_v = 1'b0;
    repeat (6) begin @(negedge clk); if (!acc_rdy) low++; @(posedge clk); #1; end
    n_total += 2;
    if (low !== 3 * (HEAP_LAT + 1)) $display("FAIL b2b_acc_rdy_low: got %0d cycles required %0d", low, 3 * (HEAP_LAT + 1)); else n_pass++;
    if (usr_rst_cnt - u0 !== 3) $display("FAIL b2b_frames: got %0d required 3", usr_rst_cnt - u0); else n_pass++;
    wait_idle("b2b");
  endtask

  task automatic test_stall();
    int u0 = usr_rst_cnt, h0 = hs_cnt, hi = 0, u1;
    out_rdy = 1'b1;
    feed(ACC_LEN, 1);
    out_rdy = 1'b0;
    feed(ACC_LEN, 1);
    u1 = usr_rst_cnt;
    repeat (80) begin @(negedge clk); if (acc_rdy) hi++; @(posedge clk); #1; end
    n_total += 4;
    if (hi !== 0) $display("FAIL stall_acc_rdy: high %0d cycles required 0", hi); else n_pass++;
    if (usr_rst_cnt - u0 !== 1 || usr_rst_cnt !== u1) $display("FAIL stall_usr_rst: got %0d pulses required 1", usr_rst_cnt - u0); else n_pass++;
    if (out_v !== 1'b1) $display("FAIL stall_out_v: got %b required 1", out_v); else n_pass++;
    if (hs_cnt - h0 !== 0) $display("FAIL stall_handshakes: got %0d required 0", hs_cnt - h0); else n_pass++;
    out_rdy = 1'b1;
    wait_idle("stall");
    n_total += 2;
    if (hs_cnt - h0 !== 2 * NB) $display("FAIL stall_drained: got %0d beats required %0d", hs_cnt - h0, 2 * NB); else n_pass++;
    if (usr_rst_cnt - u0 !== 2) $display("FAIL stall_frames: got %0d required 2", usr_rst_cnt - u0); else n_pass++;
  endtask

  task automatic test_random_ready();
    int u0 = usr_rst_cnt, h0 = hs_cnt;
    logic done = 1'b0;
    fork
      begin feed(ACC_LEN, 2); feed(ACC_LEN, 2); done = 1'b1; end
      begin while (!done) begin @(posedge clk); #1; out_rdy = 1'($urandom_range(0, 1)); end end
    join
    out_rdy = 1'b1;
    wait_idle("rand");
    n_total += 2;
    if (hs_cnt - h0 !== 2 * NB) $display("FAIL rand_beats: got %0d required %0d", hs_cnt - h0, 2 * NB); else n_pass++;
    if (usr_rst_cnt - u0 !== 2) $display("FAIL rand_frames: got %0d required 2", usr_rst_cnt - u0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int u0, h0, g = 0;
    out_rdy = 1'b1;
    // reset while WAIT counts down
    feed(ACC_LEN, 1);
    u0 = usr_rst_cnt; h0 = hs_cnt;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({acc_rdy, usr_rst, out_v, out_last, busy} !== 5'b10000 || out_data !== 64'h0) $display("FAIL rstwait_outputs: got %b/%h required 10000/0", {acc_rdy, usr_rst, out_v, out_last, busy}, out_data); else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    repeat (10) @(posedge clk); #1;
    n_total += 2;
    if (usr_rst_cnt !== u0) $display("FAIL rstwait_no_usr_rst: got %0d pulses required 0", usr_rst_cnt - u0); else n_pass++;
    if (hs_cnt !== h0) $display("FAIL rstwait_no_drain: got %0d beats required 0", hs_cnt - h0); else n_pass++;
    // reset in the middle of a drain
    feed(ACC_LEN, 1);
    h0 = hs_cnt;
    while (hs_cnt - h0 < 4 && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({acc_rdy, usr_rst, out_v, out_last, busy} !== 5'b10000 || out_data !== 64'h0) $display("FAIL rstdrain_outputs: got %b/%h required 10000/0", {acc_rdy, usr_rst, out_v, out_last, busy}, out_data); else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    u0 = usr_rst_cnt; h0 = hs_cnt;
    repeat (5) @(posedge clk); #1;
    n_total++;
    if (usr_rst_cnt !== u0 || out_v !== 1'b0) $display("FAIL rstdrain_quiet: usr_rst=%0d out_v=%b required 0/0", usr_rst_cnt - u0, out_v); else n_pass++;
    // next frame starts counting from zero
    feed(ACC_LEN, 0);
    wait_idle("rstnext");
    n_total += 2;
    if (usr_rst_cnt - u0 !== 1 || usr_rst_cyc - last_acc_cyc !== HEAP_LAT + 1) $display("FAIL rstnext_snap: pulses %0d latency %0d required 1/%0d", usr_rst_cnt - u0, usr_rst_cyc - last_acc_cyc, HEAP_LAT + 1); else n_pass++;
    if (hs_cnt - h0 !== NB) $display("FAIL rstnext_beats: got %0d required %0d", hs_cnt - h0, NB); else n_pass++;
  endtask

  task automatic test_relu();
    int g = 0;
    logic [31:0] exp01;
`ifdef REGHEAP_DRAIN_RELU_EN
    exp01 = 32'h7FFF_0000;
`else
    exp01 = 32'h7FFF_FFFE;
`endif
    out_rdy = 1'b1;
    feed(ACC_LEN, 3);
    while (!out_v && g < 20) begin @(negedge clk); g++; end
    n_total++;
    if (out_data[31:0] !== exp01) $display("FAIL relu_lanes01: got %h required %h", out_data[31:0], exp01); else n_pass++;
    wait_idle("relu");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_random_ready();
    test_reset_mid();
    test_relu();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
